// File: rtl/la_pkg.sv
// la_pkg: shared state encoding and default widths for the logic-analyser capture path
package la_pkg;
  localparam int WIDTH_DEF    = 8;
  localparam int DIV_BITS_DEF = 16;
  localparam int CNT_BITS_DEF = 16;
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } state_e;
endpackage

// File: rtl/sample_capture_tick_divider.sv
// tick_divider: prescaler that emits one tick every divider+1 enabled clocks
module tick_divider import la_pkg::*; #(
  parameter int DIV_BITS = DIV_BITS_DEF
) (
  input  logic                clk,
  input  logic                nReset,
  input  logic                en,
  input  logic                clr,
  input  logic [DIV_BITS-1:0] divider,
  output logic                tick
);
  logic [DIV_BITS-1:0] cnt_q, cnt_d;
  assign tick = en && !clr && cnt_q == divider;
  // clear wins, then hold when disabled, else count up and wrap on the tick
  always_comb cnt_d = clr ? '0 : !en ? cnt_q : tick ? '0 : cnt_q + 1'b1;
  // prescaler register
  always_ff @(posedge clk or negedge nReset)
    if (!nReset) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/sample_capture.sv
// sample_capture: triggered logic-analyser acquisition front end feeding the sample FIFO
module sample_capture import la_pkg::*; #(
  parameter int WIDTH    = WIDTH_DEF,
  parameter int DIV_BITS = DIV_BITS_DEF,
  parameter int CNT_BITS = CNT_BITS_DEF
) (
  input  logic                clk,
  input  logic                nReset,
  input  logic [WIDTH-1:0]    probe,
  input  logic                start,
  input  logic                abort,
  input  logic [DIV_BITS-1:0] divider,
  input  logic [WIDTH-1:0]    trigMask,
  input  logic [WIDTH-1:0]    trigValue,
  input  logic [CNT_BITS-1:0] sampleCount,
  input  logic                fifoFull,
  output logic                fifoWrite,
  output logic [WIDTH-1:0]    fifoWriteData,
  output logic                busy,
  output logic                done,
  output logic                overflow,
  output logic [1:0]          state
);
  state_e              state_q, state_d;
  logic [WIDTH-1:0]    meta_q, sync_q;
  logic [DIV_BITS-1:0] div_q, div_d;
  logic [WIDTH-1:0]    mask_q, mask_d, value_q, value_d, data_q, data_d;
  logic [CNT_BITS-1:0] total_q, total_d, cnt_q, cnt_d, cnt_inc;
  logic                done_q, done_d, ovf_q, ovf_d, wr_q, wr_d;
  logic                active, tick, hit, take;
  assign active  = state_q == ST_ARMED || state_q == ST_CAPTURE;
  assign hit     = ((sync_q ^ value_q) & mask_q) == '0;
  assign take    = tick && (state_q == ST_CAPTURE || hit);
  assign cnt_inc = cnt_q + 1'b1;
  tick_divider #(.DIV_BITS(DIV_BITS)) u_div (
    .clk     (clk),
    .nReset  (nReset),
    .en      (active),
    .clr     (!active),
    .divider (div_q),
    .tick    (tick)
  );
  // two-flop synchroniser for the asynchronous probe pins
  always_ff @(posedge clk or negedge nReset)
    if (!nReset) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= probe;
      sync_q <= meta_q;
    end
  // next state: abort beats start, start only from IDLE/DONE, then per-tick sampling
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    mask_d  = mask_q;
    value_d = value_q;
    total_d = total_q;
    cnt_d   = cnt_q;
    done_d  = done_q;
    ovf_d   = ovf_q;
    wr_d    = 1'b0;
    data_d  = data_q;
    if (abort) begin
      state_d = ST_IDLE;
      done_d  = 1'b0;
    end else if (start && !active) begin
      div_d   = divider;
      mask_d  = trigMask;
      value_d = trigValue;
      total_d = sampleCount;
      cnt_d   = '0;
      ovf_d   = 1'b0;
      state_d = sampleCount == '0 ? ST_DONE : ST_ARMED;
      done_d  = sampleCount == '0;
    end else if (take) begin
      cnt_d   = cnt_inc;
      wr_d    = !fifoFull;
      ovf_d   = ovf_q | fifoFull;
      data_d  = sync_q;
      state_d = cnt_inc == total_q ? ST_DONE : ST_CAPTURE;
      done_d  = cnt_inc == total_q;
    end
  end
  // state, latched config, counter and registered write port
  always_ff @(posedge clk or negedge nReset)
    if (!nReset) begin
      state_q <= ST_IDLE;
      div_q   <= '0;
      mask_q  <= '0;
      value_q <= '0;
      total_q <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
      wr_q    <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      mask_q  <= mask_d;
      value_q <= value_d;
      total_q <= total_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
      wr_q    <= wr_d;
      data_q  <= data_d;
    end
  assign fifoWrite     = wr_q;
  assign fifoWriteData = data_q;
  assign busy          = active;
  assign done          = done_q;
  assign overflow      = ovf_q;
  assign state         = state_q;
endmodule

// File: tb/tb_sample_capture.sv
// tb_sample_capture: directed and randomized checks against a tick-schedule reference model
module tb_sample_capture;
  logic clk = 1'b0, nReset = 1'b1, start = 1'b0, abort = 1'b0, fifoFull = 1'b0;
  logic [7:0] probe = '0, trigMask = '0, trigValue = '0;
  logic [15:0] divider = '0, sampleCount = '0;
  logic fifoWrite, busy, done, overflow;
  logic [7:0] fifoWriteData;
  logic [1:0] state;
  int checks = 0, errors = 0, cyc = 0, wr_cnt = 0;
  int wr_cyc[$];
  bit [7:0] ph [8192];
  int m_state = 0, m_s = 0, m_div = 0, m_cnt = 0, m_taken = 0;
  bit m_done = 0, m_ovf = 0, exp_wr = 0;
  bit [7:0] m_mask = 0, m_val = 0, exp_data = 0;
  int gap;
  always #5 clk = ~clk;
  sample_capture dut (
    .clk           (clk),
    .nReset        (nReset),
    .probe         (probe),
    .start         (start),
    .abort         (abort),
    .divider       (divider),
    .trigMask      (trigMask),
    .trigValue     (trigValue),
    .sampleCount   (sampleCount),
    .fifoFull      (fifoFull),
    .fifoWrite     (fifoWrite),
    .fifoWriteData (fifoWriteData),
    .busy          (busy),
    .done          (done),
    .overflow      (overflow),
    .state         (state)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask
  // Reference: ticks fall every divider+1 clocks counted from the start edge; the sample
  // seen at a tick is the probe value driven two edges earlier.
  task automatic model();
    bit [7:0] smp;
    exp_wr = 0;
    if (abort) begin
      m_state = 0;
      m_done  = 0;
    end else if (start && (m_state == 0 || m_state == 3)) begin
      m_div = int'(divider); m_cnt = int'(sampleCount);
      m_mask = trigMask; m_val = trigValue;
      m_s = cyc; m_taken = 0; m_ovf = 0;
      m_state = (m_cnt == 0) ? 3 : 1;
      m_done = (m_cnt == 0);
    end else if ((m_state == 1 || m_state == 2) && (cyc - m_s) % (m_div + 1) == 0) begin
      smp = ph[cyc-2];
      if (m_state == 2 || (smp & m_mask) == (m_val & m_mask)) begin
        m_taken++;
        if (fifoFull) m_ovf = 1;
        else begin
          exp_wr = 1;
          exp_data = smp;
        end
        m_state = (m_taken == m_cnt) ? 3 : 2;
        if (m_taken == m_cnt) m_done = 1;
      end
    end
  endtask
  task automatic step();
    @(posedge clk);
    cyc++;
    ph[cyc] = probe;
    model();
    #1;
    if (fifoWrite) begin
      wr_cnt++;
      wr_cyc.push_back(cyc);
    end
    chk("state", 32'(state), m_state);
    chk("busy", 32'(busy), 32'(m_state == 1 || m_state == 2));
    chk("done", 32'(done), 32'(m_done));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("fifoWrite", 32'(fifoWrite), 32'(exp_wr));
    if (exp_wr) chk("fifoWriteData", 32'(fifoWriteData), 32'(exp_data));
  endtask
  task automatic launch(input int d, input int n, input bit [7:0] mk, input bit [7:0] vl);
    divider = 16'(d); sampleCount = 16'(n); trigMask = mk; trigValue = vl;
    wr_cnt = 0; wr_cyc.delete();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, "_state"}, 32'(state), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_ovf"}, 32'(overflow), 0);
    chk({tag, "_wr"}, 32'(fifoWrite), 0);
    chk({tag, "_data"}, 32'(fifoWriteData), 0);
  endtask
  initial begin
    #1 nReset = 1'b0;
    #1 chk_zero("reset");
    repeat (2) @(posedge clk);
    #3 nReset = 1'b1;
    repeat (3) step();
    // consecutive writes with divider 0 and an empty mask
    probe = 8'h10;
    launch(0, 4, 8'h00, 8'h00);
    for (int i = 1; i <= 8; i++) begin
      probe = 8'h10 + 8'(i);
      step();
    end
    chk("t1_writes", 32'(wr_cnt), 4);
    gap = (wr_cyc.size() == 4) ? wr_cyc[3] - wr_cyc[0] : -1;
    chk("t1_span", gap, 3);
    chk("t1_state", 32'(state), 3);
    // masked trigger on bit 7 with divider 3
    probe = 8'h00;
    launch(3, 2, 8'h80, 8'h80);
    for (int i = 0; i < 30; i++) begin
      probe = (i >= 10) ? (8'h80 | 8'($urandom)) : (8'h7f & 8'($urandom));
      step();
    end
    chk("t2_writes", 32'(wr_cnt), 2);
    gap = (wr_cyc.size() == 2) ? wr_cyc[1] - wr_cyc[0] : -1;
    chk("t2_gap", gap, 4);
    chk("t2_done", 32'(done), 1);
    // full FIFO on the third tick drops exactly one sample
    launch(1, 5, 8'h00, 8'h00);
    for (int i = 0; i < 12; i++) begin
      probe = 8'($urandom);
      fifoFull = (cyc + 1 == m_s + 6);
      step();
    end
    fifoFull = 1'b0;
    chk("t3_writes", 32'(wr_cnt), 4);
    chk("t3_overflow", 32'(overflow), 1);
    chk("t3_done", 32'(done), 1);
    // abort after two of ten samples
    launch(2, 10, 8'h00, 8'h00);
    for (int i = 0; i < 40 && wr_cnt < 2; i++) begin
      probe = 8'($urandom);
      step();
    end
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("t4_idle", 32'(state), 0);
    repeat (10) step();
    chk("t4_writes", 32'(wr_cnt), 2);
    chk("t4_done", 32'(done), 0);
    // start and abort together, then a zero-length capture
    start = 1'b1; abort = 1'b1;
    step();
    start = 1'b0; abort = 1'b0;
    chk("t5_idle", 32'(state), 0);
    launch(0, 0, 8'h00, 8'h00);
    repeat (4) step();
    chk("t5_done", 32'(done), 1);
    chk("t5_state", 32'(state), 3);
    chk("t5_writes", 32'(wr_cnt), 0);
    // asynchronous reset in the middle of a capture
    launch(0, 20, 8'h00, 8'h00);
    repeat (5) begin
      probe = 8'($urandom) | 8'h01;
      step();
    end
    #3 nReset = 1'b0;
    #1 chk_zero("t6_async");
    m_state = 0; m_done = 0; m_ovf = 0; exp_wr = 0;
    repeat (2) begin
      @(posedge clk);
      cyc++;
      ph[cyc] = '0;
    end
    #3 nReset = 1'b1;
    probe = 8'h5a;
    launch(1, 3, 8'h00, 8'h00);
    chk("t6_armed", 32'(state), 1);
    for (int i = 0; i < 20 && m_state != 3; i++) begin
      probe = 8'($urandom);
      step();
    end
    chk("t6_writes", 32'(wr_cnt), 3);
    // randomized captures with changing inputs and spurious starts while busy
    for (int r = 0; r < 6; r++) begin
      launch(int'($urandom_range(0, 3)), int'($urandom_range(1, 6)),
             8'(1 << $urandom_range(0, 7)) | 8'(1 << $urandom_range(0, 7)), 8'($urandom));
      for (int i = 0; i < 300 && m_state != 3; i++) begin
        probe = 8'($urandom);
        fifoFull = ($urandom_range(0, 99) < 15);
        divider = 16'($urandom);
        sampleCount = 16'($urandom);
        start = ($urandom_range(0, 99) < 5);
        step();
      end
      start = 1'b0; fifoFull = 1'b0;
      chk("rand_done", 32'(done), 1);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
